// File: rtl/regfile_stats_scanner.sv
// regfile_stats_scanner: register file of 2**ADDR_W entries with a built-in
// min/max scanner that sweeps one even/odd pair per cycle.
//
// Handshake: a scan is requested by start=1 at a rising edge while idle
// (busy=0). busy then stays high while pairs are consumed. valid pulses for
// one cycle when max/min/max_idx/min_idx hold the new result. A start that
// arrives while busy is dropped and is not queued. A write that arrives while
// busy is dropped, and wr_err pulses once for it.
module regfile_stats_scanner #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  output logic              busy,
  output logic              valid,
  output logic              wr_err,
  output logic [DATA_W-1:0] max,
  output logic [DATA_W-1:0] min,
  output logic [ADDR_W-1:0] max_idx,
  output logic [ADDR_W-1:0] min_idx
);

  localparam int DEPTH = 2 ** ADDR_W;
  // The pair counter keeps at least one bit, so it stays legal when DEPTH is 2.
  localparam int PW = (ADDR_W > 1) ? ADDR_W - 1 : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH / 2 - 1);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t            state, state_next;
  logic [PW-1:0]     p, p_next;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              last_pair;
  logic [ADDR_W-1:0] even_addr, odd_addr;
  logic [DATA_W-1:0] even_val, odd_val;
  logic [DATA_W-1:0] pair_max, pair_min;
  logic [ADDR_W-1:0] pair_max_idx, pair_min_idx;
  logic [DATA_W-1:0] cand_max, cand_min;
  logic [ADDR_W-1:0] cand_max_idx, cand_min_idx;
  logic [DATA_W-1:0] run_max, run_min;
  logic [ADDR_W-1:0] run_max_idx, run_min_idx;

  // Strict greater-than in the configured number format.
  function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    else             return a > b;
  endfunction

  assign last_pair = (p == LAST);
  assign busy      = (state == SCAN);

  // State register: FSM state and pair counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      p     <= '0;
    end else begin
      state <= state_next;
      p     <= p_next;
    end
  end

  // Next-state logic: leave IDLE on start, return after the last pair.
  always_comb begin
    state_next = state;
    p_next     = p;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SCAN;
          p_next     = '0;
        end
      end
      SCAN: begin
        if (last_pair) begin
          state_next = IDLE;
          p_next     = '0;
        end else begin
          p_next = p + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        p_next     = '0;
      end
    endcase
  end

  // Output logic: compare the current pair, then merge it with the running result.
  // Each side takes the higher index only on a strict win, so the lowest index wins ties.
  always_comb begin
    even_addr    = ADDR_W'({p, 1'b0});
    odd_addr     = ADDR_W'({p, 1'b1});
    even_val     = mem[even_addr];
    odd_val      = mem[odd_addr];
    pair_max     = even_val;
    pair_max_idx = even_addr;
    pair_min     = even_val;
    pair_min_idx = even_addr;
    if (gt(odd_val, even_val)) begin
      pair_max     = odd_val;
      pair_max_idx = odd_addr;
    end
    if (gt(even_val, odd_val)) begin
      pair_min     = odd_val;
      pair_min_idx = odd_addr;
    end
    cand_max     = run_max;
    cand_max_idx = run_max_idx;
    cand_min     = run_min;
    cand_min_idx = run_min_idx;
    if (p == '0 || gt(pair_max, run_max)) begin
      cand_max     = pair_max;
      cand_max_idx = pair_max_idx;
    end
    if (p == '0 || gt(run_min, pair_min)) begin
      cand_min     = pair_min;
      cand_min_idx = pair_min_idx;
    end
  end

  // Register file: writes are accepted only while idle, so a scan sees a stable snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en && state == IDLE) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Running result, committed outputs, and the valid and wr_err pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_max     <= '0;
      run_min     <= '0;
      run_max_idx <= '0;
      run_min_idx <= '0;
      max         <= '0;
      min         <= '0;
      max_idx     <= '0;
      min_idx     <= '0;
      valid       <= 1'b0;
      wr_err      <= 1'b0;
    end else begin
      valid  <= 1'b0;
      wr_err <= wr_en && (state == SCAN);
      if (state == SCAN) begin
        run_max     <= cand_max;
        run_min     <= cand_min;
        run_max_idx <= cand_max_idx;
        run_min_idx <= cand_min_idx;
        if (last_pair) begin
          max     <= cand_max;
          min     <= cand_min;
          max_idx <= cand_max_idx;
          min_idx <= cand_min_idx;
          valid   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_stats_scanner.sv
// Bench for regfile_stats_scanner (8x16). An unsigned and a signed instance
// share every input. A linear-scan model of the register file predicts the
// results of both instances.
module tb_regfile_stats_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        start = 1'b0;

  logic        busy_u, valid_u, wr_err_u, busy_s, valid_s, wr_err_s;
  logic [15:0] max_u, min_u, max_s, min_s;
  logic [2:0]  max_idx_u, min_idx_u, max_idx_s, min_idx_s;

  int total = 0;
  int bad = 0;
  logic [15:0] model_mem [8];

  regfile_stats_scanner #(.DATA_W(16), .ADDR_W(3), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy_u), .valid(valid_u), .wr_err(wr_err_u),
    .max(max_u), .min(min_u), .max_idx(max_idx_u), .min_idx(min_idx_u)
  );

  regfile_stats_scanner #(.DATA_W(16), .ADDR_W(3), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy_s), .valid(valid_s), .wr_err(wr_err_s),
    .max(max_s), .min(min_s), .max_idx(max_idx_s), .min_idx(min_idx_s)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain linear scan where a later entry wins only on a strict improvement.
  function automatic bit m_gt(bit sgn, logic [15:0] a, logic [15:0] b);
    if (sgn) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  task automatic model_scan(input bit sgn, output logic [15:0] mx, output logic [15:0] mn,
                            output logic [2:0] mxi, output logic [2:0] mni);
    mx = model_mem[0]; mn = model_mem[0]; mxi = 0; mni = 0;
    for (int i = 1; i < 8; i++) begin
      if (m_gt(sgn, model_mem[i], mx)) begin mx = model_mem[i]; mxi = 3'(i); end
      if (m_gt(sgn, mn, model_mem[i])) begin mn = model_mem[i]; mni = 3'(i); end
    end
  endtask

  // Driver tasks
  task automatic do_write(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    model_mem[a] = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic fill(input logic [15:0] v [8]);
    for (int i = 0; i < 8; i++) do_write(3'(i), v[i]);
  endtask

  // Issue start (optionally with a write in the same cycle), wait for valid, and check the results.
  task automatic run_scan(input string tag, input bit wr, input logic [2:0] a, input logic [15:0] d);
    int n, busy_cnt;
    logic [15:0] obs [8];
    logic [15:0] ex [8];
    logic [15:0] mx, mn;
    logic [2:0]  mxi, mni;
    if (wr) begin
      wr_en = 1'b1; wr_addr = a; wr_data = d; model_mem[a] = d;
    end
    start = 1'b1;
    tick();
    start = 1'b0; wr_en = 1'b0;
    n = 0; busy_cnt = 0;
    while (!valid_u && n < 20) begin
      if (busy_u && busy_s) busy_cnt++;
      tick();
      n++;
    end
    total++;
    if (n !== 4 || valid_s !== 1'b1) begin
      $display("FAIL %s latency: got %0d cycles (valid_s=%b), want 4", tag, n, valid_s); bad++;
    end
    total++;
    if (busy_cnt !== 4 || busy_u !== 1'b0 || busy_s !== 1'b0) begin
      $display("FAIL %s busy: got %0d busy cycles, busy at valid=%b/%b, want 4 and 0", tag, busy_cnt, busy_u, busy_s); bad++;
    end
    model_scan(1'b0, mx, mn, mxi, mni);
    ex[0] = mx; ex[1] = mn; ex[2] = {13'b0, mxi}; ex[3] = {13'b0, mni};
    model_scan(1'b1, mx, mn, mxi, mni);
    ex[4] = mx; ex[5] = mn; ex[6] = {13'b0, mxi}; ex[7] = {13'b0, mni};
    obs[0] = max_u; obs[1] = min_u; obs[2] = {13'b0, max_idx_u}; obs[3] = {13'b0, min_idx_u};
    obs[4] = max_s; obs[5] = min_s; obs[6] = {13'b0, max_idx_s}; obs[7] = {13'b0, min_idx_s};
    for (int i = 0; i < 8; i++) begin
      total++;
      if (obs[i] !== ex[i]) begin
        $display("FAIL %s result[%0d] (max,min,max_idx,min_idx x unsigned,signed): got %h want %h", tag, i, obs[i], ex[i]);
        bad++;
      end
    end
  endtask

  // Scenario tasks
  task automatic test_reset();
    total++;
    if ({busy_u, valid_u, wr_err_u, max_u, min_u, max_idx_u, min_idx_u} !== '0 ||
        {busy_s, valid_s, wr_err_s, max_s, min_s, max_idx_s, min_idx_s} !== '0) begin
      $display("FAIL reset_state: outputs not all zero (u max=%h min=%h, s max=%h min=%h)", max_u, min_u, max_s, min_s);
      bad++;
    end
  endtask

  task automatic test_empty();
    run_scan("empty", 1'b0, 3'd0, 16'd0);
    tick();
    total++;
    if (valid_u !== 1'b0 || valid_s !== 1'b0) begin
      $display("FAIL empty_valid_pulse: valid=%b/%b one cycle later, want 0", valid_u, valid_s); bad++;
    end
  endtask

  task automatic test_basic();
    logic [15:0] v [8];
    v = '{16'd5, 16'd9, 16'd1, 16'd7, 16'd3, 16'd8, 16'd2, 16'd6};
    fill(v);
    run_scan("basic", 1'b0, 3'd0, 16'd0);
    total++;
    if (max_u !== 16'd9 || max_idx_u !== 3'd1 || min_u !== 16'd1 || min_idx_u !== 3'd2) begin
      $display("FAIL basic_fixed: got max=%0d@%0d min=%0d@%0d, want 9@1 1@2", max_u, max_idx_u, min_u, min_idx_u); bad++;
    end
  endtask

  task automatic test_write_during_scan();
    logic [15:0] e_max, e_min;
    logic [2:0]  e_mxi, e_mni;
    int n, stray;
    model_scan(1'b0, e_max, e_min, e_mxi, e_mni);
    start = 1'b1; tick(); start = 1'b0;          // first SCAN cycle
    tick();                                      // second SCAN cycle
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'hFFFF; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    total++;
    if (wr_err_u !== 1'b1 || wr_err_s !== 1'b1) begin
      $display("FAIL wr_err_pulse: got %b/%b, want 1", wr_err_u, wr_err_s); bad++;
    end
    tick();
    total++;
    if (wr_err_u !== 1'b0 || wr_err_s !== 1'b0) begin
      $display("FAIL wr_err_one_cycle: got %b/%b, want 0", wr_err_u, wr_err_s); bad++;
    end
    n = 0;
    while (!valid_u && n < 10) begin tick(); n++; end
    total++;
    if (n !== 1 || max_u !== e_max || max_idx_u !== e_mxi || min_u !== e_min || min_idx_u !== e_mni) begin
      $display("FAIL wr_during_scan_result: n=%0d max=%h@%0d min=%h@%0d, want n=1 %h@%0d %h@%0d",
               n, max_u, max_idx_u, min_u, min_idx_u, e_max, e_mxi, e_min, e_mni); bad++;
    end
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy_u || valid_u || busy_s || valid_s) stray++;
    end
    total++;
    if (stray !== 0) begin
      $display("FAIL start_in_scan_ignored: got %0d busy/valid cycles after the scan, want 0", stray); bad++;
    end
    run_scan("rescan_after_dropped_write", 1'b0, 3'd0, 16'd0);
  endtask

  task automatic test_ties();
    logic [15:0] v [8];
    v = '{16'h10, 16'h10, 16'h10, 16'hFF, 16'h10, 16'hFF, 16'h10, 16'h10};
    fill(v);
    run_scan("ties", 1'b0, 3'd0, 16'd0);
    total++;
    if (max_idx_u !== 3'd3 || min_idx_u !== 3'd0) begin
      $display("FAIL ties_fixed: got max_idx=%0d min_idx=%0d, want 3 0", max_idx_u, min_idx_u); bad++;
    end
  endtask

  task automatic test_signed();
    logic [15:0] v [8];
    v = '{16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h7FFF, 16'h0, 16'h0, 16'h0};
    fill(v);
    run_scan("signed", 1'b0, 3'd0, 16'd0);
    total++;
    if (max_s !== 16'h7FFF || max_idx_s !== 3'd4 || min_s !== 16'hFFFF || min_idx_s !== 3'd0) begin
      $display("FAIL signed_fixed: got max=%h@%0d min=%h@%0d, want 7fff@4 ffff@0", max_s, max_idx_s, min_s, min_idx_s); bad++;
    end
    total++;
    if (max_u !== 16'hFFFF || max_idx_u !== 3'd0 || min_u !== 16'h0 || min_idx_u !== 3'd1) begin
      $display("FAIL unsigned_fixed: got max=%h@%0d min=%h@%0d, want ffff@0 0000@1", max_u, max_idx_u, min_u, min_idx_u); bad++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v [8];
    for (int i = 0; i < 8; i++) v[i] = 16'($urandom_range(0, 65535));
    fill(v);
    run_scan("b2b_first", 1'b0, 3'd0, 16'd0);
    // start again in the valid cycle, with a write in the same cycle that the scan must see
    run_scan("b2b_second", 1'b1, 3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)));
  endtask

  task automatic test_random();
    logic [15:0] v [8];
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++)
        v[i] = (r % 2 == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 3)) << 14;
      fill(v);
      run_scan($sformatf("random_%0d", r), 1'b1, 3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)));
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
    end
  endtask

  task automatic test_reset_mid_scan();
    int stray;
    logic [15:0] v [8];
    v = '{16'h0100, 16'h8001, 16'h0003, 16'h7000, 16'h0050, 16'h0060, 16'h0070, 16'h0080};
    fill(v);
    run_scan("pre_reset", 1'b0, 3'd0, 16'd0);
    tick();
    start = 1'b1; tick(); start = 1'b0;          // first SCAN cycle
    tick();                                      // second SCAN cycle
    tick();                                      // third SCAN cycle
    rst = 1'b1;
    #1;
    total++;
    if ({busy_u, valid_u, wr_err_u, max_u, min_u, max_idx_u, min_idx_u} !== '0 ||
        {busy_s, valid_s, wr_err_s, max_s, min_s, max_idx_s, min_idx_s} !== '0) begin
      $display("FAIL reset_mid_scan_clear: busy=%b max=%h min=%h (signed max=%h), want all zero", busy_u, max_u, min_u, max_s);
      bad++;
    end
    for (int i = 0; i < 8; i++) model_mem[i] = '0;
    tick(); tick();
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid_u || valid_s || busy_u || busy_s) stray++;
    end
    total++;
    if (stray !== 0) begin
      $display("FAIL reset_mid_scan_no_valid: got %0d busy/valid cycles, want 0", stray); bad++;
    end
    do_write(3'd2, 16'h1234);
    run_scan("after_reset", 1'b0, 3'd0, 16'd0);
    total++;
    if (max_u !== 16'h1234 || max_idx_u !== 3'd2 || min_u !== 16'h0 || min_idx_u !== 3'd0) begin
      $display("FAIL after_reset_fixed: got max=%h@%0d min=%h@%0d, want 1234@2 0000@0", max_u, max_idx_u, min_u, min_idx_u); bad++;
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model_mem[i] = '0;
    #1;
    test_reset();
    tick(); tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_empty();
    test_basic();
    test_write_during_scan();
    test_ties();
    test_signed();
    test_back_to_back();
    test_random();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
